// File: rtl/ps2_pkg.sv
// ============================================================================
// Module : ps2_pkg
// Brief  : Shared types and constants for the PS/2 set-2 key decoder path.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_SKIP    = 3'd4
    } dec_state_t;

    localparam int EVT_W         = 12;
    localparam int EVT_MAKE_BIT  = 11;
    localparam int EVT_EXT_BIT   = 10;
    localparam int EVT_SHIFT_BIT = 9;
    localparam int EVT_CTRL_BIT  = 8;

    localparam logic [7:0] E0 = 8'hE0;
    localparam logic [7:0] E1 = 8'hE1;
    localparam logic [7:0] F0 = 8'hF0;

    localparam logic [7:0] LSHIFT = 8'h12;
    localparam logic [7:0] RSHIFT = 8'h59;
    localparam logic [7:0] CTRL   = 8'h14;
    localparam logic [7:0] CAPS   = 8'h58;

    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    function automatic logic [EVT_W-1:0] pack_event(
        input logic       make,
        input logic       ext,
        input logic       shift_held,
        input logic       ctrl_held,
        input logic [7:0] code
    );
        return {make, ext, shift_held, ctrl_held, code};
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_event_fifo.sv
// ============================================================================
// Module : key_event_fifo
// Brief  : Synchronous FIFO with push/full, pop/empty and occupancy count.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module key_event_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ps2_key_decoder.sv
// ============================================================================
// Module : ps2_key_decoder
// Brief  : Set-2 scan-code decoder with modifier tracking and an event FIFO.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH      = 8,
    parameter int SUPPRESS_REPEAT = 1,
    parameter int EXT_ENABLE      = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ack,
    output logic             evt_valid,
    output logic [EVT_W-1:0] evt_data,
    input  logic             evt_ready,
    output logic             shift,
    output logic             ctrl,
    output logic             caps_lock,
    output logic             overflow
);

    dec_state_t  state_q, state_d;
    logic [2:0]  skip_q, skip_d;
    logic        ack_q, ack_d;
    logic        lshift_q, lshift_d;
    logic        rshift_q, rshift_d;
    logic        lctrl_q, lctrl_d;
    logic        rctrl_q, rctrl_d;
    logic        caps_q, caps_d;
    logic        caps_held_q, caps_held_d;
    logic [8:0]  held_q, held_d;
    logic        held_valid_q, held_valid_d;
    logic        overflow_q, overflow_d;

    logic             consume;
    logic             ev_fire;
    logic             ev_make;
    logic             ev_ext;
    logic [8:0]       ev_key;
    logic             is_repeat;
    logic             push_req;
    logic [EVT_W-1:0] push_word;

    logic                          fifo_full;
    logic                          fifo_empty;
    logic                          fifo_pop;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;

    assign consume  = byte_valid && !ack_q;
    assign fifo_pop = evt_ready && !fifo_empty;
    assign ev_key   = {ev_ext, byte_data};

    always_comb begin
        state_d      = state_q;
        skip_d       = skip_q;
        ack_d        = consume;
        lshift_d     = lshift_q;
        rshift_d     = rshift_q;
        lctrl_d      = lctrl_q;
        rctrl_d      = rctrl_q;
        caps_d       = caps_q;
        caps_held_d  = caps_held_q;
        held_d       = held_q;
        held_valid_d = held_valid_q;
        overflow_d   = overflow_q;
        ev_fire      = 1'b0;
        ev_make      = 1'b0;
        ev_ext       = 1'b0;
        is_repeat    = 1'b0;

        if (consume) begin
            case (state_q)
                ST_IDLE: begin
                    if (byte_data == E0) begin
                        state_d = ST_EXT;
                    end else if (byte_data == F0) begin
                        state_d = ST_BRK;
                    end else if (byte_data == E1) begin
                        state_d = ST_SKIP;
                        skip_d  = PAUSE_SKIP;
                    end else begin
                        ev_fire = 1'b1;
                        ev_make = 1'b1;
                    end
                end
                ST_EXT: begin
                    state_d = ST_IDLE;
                    if (byte_data == F0) begin
                        state_d = ST_EXT_BRK;
                    end else if (byte_data != LSHIFT) begin
                        ev_fire = 1'b1;
                        ev_make = 1'b1;
                        ev_ext  = 1'b1;
                    end
                end
                ST_BRK: begin
                    state_d = ST_IDLE;
                    ev_fire = 1'b1;
                end
                ST_EXT_BRK: begin
                    state_d = ST_IDLE;
                    // E0-prefixed 12 is the keyboard's synthetic shift; drop it.
                    if (byte_data != LSHIFT) begin
                        ev_fire = 1'b1;
                        ev_ext  = 1'b1;
                    end
                end
                ST_SKIP: begin
                    skip_d = skip_q - 1'b1;
                    if (skip_q <= 3'd1) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (ev_fire) begin
            if (!ev_ext && byte_data == LSHIFT) lshift_d = ev_make;
            if (!ev_ext && byte_data == RSHIFT) rshift_d = ev_make;
            if (!ev_ext && byte_data == CTRL)   lctrl_d  = ev_make;
            if ( ev_ext && byte_data == CTRL)   rctrl_d  = ev_make;

            if (ev_make) begin
                if ((SUPPRESS_REPEAT != 0) && held_valid_q && (held_q == ev_key)) begin
                    is_repeat = 1'b1;
                end else begin
                    held_d       = ev_key;
                    held_valid_d = 1'b1;
                end
                // Caps toggles once per physical press, never on typematic repeats.
                if (!ev_ext && byte_data == CAPS && !caps_held_q) begin
                    caps_d      = ~caps_q;
                    caps_held_d = 1'b1;
                end
            end else begin
                if (held_valid_q && (held_q == ev_key)) begin
                    held_valid_d = 1'b0;
                end
                if (!ev_ext && byte_data == CAPS) begin
                    caps_held_d = 1'b0;
                end
            end
        end

        push_req = ev_fire && !is_repeat && ((EXT_ENABLE != 0) || !ev_ext);
        if (push_req && fifo_full && !fifo_pop) begin
            overflow_d = 1'b1;
        end
    end

    assign push_word = pack_event(ev_make, ev_ext, lshift_d | rshift_d,
                                  lctrl_d | rctrl_d, byte_data);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= ST_IDLE;
            skip_q       <= '0;
            ack_q        <= 1'b0;
            lshift_q     <= 1'b0;
            rshift_q     <= 1'b0;
            lctrl_q      <= 1'b0;
            rctrl_q      <= 1'b0;
            caps_q       <= 1'b0;
            caps_held_q  <= 1'b0;
            held_q       <= '0;
            held_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            skip_q       <= skip_d;
            ack_q        <= ack_d;
            lshift_q     <= lshift_d;
            rshift_q     <= rshift_d;
            lctrl_q      <= lctrl_d;
            rctrl_q      <= rctrl_d;
            caps_q       <= caps_d;
            caps_held_q  <= caps_held_d;
            held_q       <= held_d;
            held_valid_q <= held_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    key_event_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (clr),
        .push      (push_req),
        .push_data (push_word),
        .full      (fifo_full),
        .pop       (fifo_pop),
        .pop_data  (evt_data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign evt_valid = (fifo_count != '0);
    assign byte_ack  = ack_q;
    assign shift     = lshift_q | rshift_q;
    assign ctrl      = lctrl_q | rctrl_q;
    assign caps_lock = caps_q;
    assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
// ============================================================================
// Module : tb_ps2_key_decoder
// Brief  : Directed bench; three decoder variants share one byte stream.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ps2_key_decoder;

    // Index 0: defaults, 1: SUPPRESS_REPEAT=0, 2: EXT_ENABLE=0
    logic        clk;
    logic        clr;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ack  [3];
    logic        evt_valid [3];
    logic [11:0] evt_data  [3];
    logic        evt_ready [3];
    logic        shift     [3];
    logic        ctrl      [3];
    logic        caps_lock [3];
    logic        overflow  [3];

    int n_checks = 0;
    int n_errors = 0;

    ps2_key_decoder #(.FIFO_DEPTH(8), .SUPPRESS_REPEAT(1), .EXT_ENABLE(1)) u_dut_def (
        .clk(clk), .clr(clr), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ack(byte_ack[0]), .evt_valid(evt_valid[0]), .evt_data(evt_data[0]),
        .evt_ready(evt_ready[0]), .shift(shift[0]), .ctrl(ctrl[0]),
        .caps_lock(caps_lock[0]), .overflow(overflow[0])
    );

    ps2_key_decoder #(.FIFO_DEPTH(8), .SUPPRESS_REPEAT(0), .EXT_ENABLE(1)) u_dut_nosup (
        .clk(clk), .clr(clr), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ack(byte_ack[1]), .evt_valid(evt_valid[1]), .evt_data(evt_data[1]),
        .evt_ready(evt_ready[1]), .shift(shift[1]), .ctrl(ctrl[1]),
        .caps_lock(caps_lock[1]), .overflow(overflow[1])
    );

    ps2_key_decoder #(.FIFO_DEPTH(8), .SUPPRESS_REPEAT(1), .EXT_ENABLE(0)) u_dut_noext (
        .clk(clk), .clr(clr), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ack(byte_ack[2]), .evt_valid(evt_valid[2]), .evt_data(evt_data[2]),
        .evt_ready(evt_ready[2]), .shift(shift[2]), .ctrl(ctrl[2]),
        .caps_lock(caps_lock[2]), .overflow(overflow[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Byte held high through the ack cycle; the second edge must not re-consume it.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge clk);
        #1 check("byte_ack_pulse", {31'd0, byte_ack[0]}, 32'd1);
        @(posedge clk);
        #1 check("byte_ack_single", {31'd0, byte_ack[0]}, 32'd0);
        byte_valid = 1'b0;
    endtask

    task automatic pop_expect(input int k, input logic [11:0] exp, input string tag);
        @(negedge clk);
        check({tag, "_valid"}, {31'd0, evt_valid[k]}, 32'd1);
        check(tag, {20'd0, evt_data[k]}, {20'd0, exp});
        evt_ready[k] = 1'b1;
        @(posedge clk);
        #1 evt_ready[k] = 1'b0;
    endtask

    task automatic expect_empty(input int k, input string tag);
        @(negedge clk);
        check(tag, {31'd0, evt_valid[k]}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr        = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        foreach (evt_ready[k]) evt_ready[k] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_evt_valid", {31'd0, evt_valid[0]}, 32'd0);
        check("rst_evt_data",  {20'd0, evt_data[0]},  32'd0);
        check("rst_byte_ack",  {31'd0, byte_ack[0]},  32'd0);
        check("rst_shift",     {31'd0, shift[0]},     32'd0);
        check("rst_ctrl",      {31'd0, ctrl[0]},      32'd0);
        check("rst_caps",      {31'd0, caps_lock[0]}, 32'd0);
        check("rst_overflow",  {31'd0, overflow[0]},  32'd0);

        // Make/break A
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h1C);
        pop_expect(0, 12'h81C, "make_a");
        pop_expect(0, 12'h01C, "break_a");
        expect_empty(0, "a_empty");
        check("a_shift", {31'd0, shift[0]}, 32'd0);

        // Shifted A with typematic repeats
        do_reset();
        send_byte(8'h12);
        @(negedge clk);
        check("shift_held", {31'd0, shift[0]}, 32'd1);
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h12);
        pop_expect(0, 12'hA12, "shift_make");
        pop_expect(0, 12'hA1C, "shift_a_make");
        pop_expect(0, 12'h21C, "shift_a_break");
        pop_expect(0, 12'h012, "shift_break");
        expect_empty(0, "repeat_dropped");
        check("shift_released", {31'd0, shift[0]}, 32'd0);

        // Extended keys and right ctrl
        do_reset();
        send_byte(8'hE0);
        send_byte(8'h14);
        @(negedge clk);
        check("noext_ctrl_up", {31'd0, ctrl[2]}, 32'd1);
        send_byte(8'hE0);
        send_byte(8'h75);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h14);
        pop_expect(0, 12'hD14, "rctrl_make");
        pop_expect(0, 12'hD75, "up_make");
        pop_expect(0, 12'h575, "up_break");
        pop_expect(0, 12'h414, "rctrl_break");
        expect_empty(2, "noext_no_events");
        check("noext_ctrl_down", {31'd0, ctrl[2]}, 32'd0);

        // Fake shift E0 12 / E0 F0 12 is discarded
        do_reset();
        send_byte(8'hE0);
        send_byte(8'h12);
        @(negedge clk);
        check("fake_shift_state", {31'd0, shift[0]}, 32'd0);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h12);
        expect_empty(0, "fake_shift_no_event");

        // Caps lock without repeat suppression
        do_reset();
        send_byte(8'h58);
        @(negedge clk);
        check("caps_on", {31'd0, caps_lock[1]}, 32'd1);
        send_byte(8'h58);
        @(negedge clk);
        check("caps_repeat", {31'd0, caps_lock[1]}, 32'd1);
        send_byte(8'hF0);
        send_byte(8'h58);
        check("caps_release", {31'd0, caps_lock[1]}, 32'd1);
        send_byte(8'h58);
        @(negedge clk);
        check("caps_off", {31'd0, caps_lock[1]}, 32'd0);
        send_byte(8'hF0);
        send_byte(8'h58);
        pop_expect(1, 12'h858, "caps_ev1");
        pop_expect(1, 12'h858, "caps_ev2");
        pop_expect(1, 12'h058, "caps_ev3");
        pop_expect(1, 12'h858, "caps_ev4");
        pop_expect(1, 12'h058, "caps_ev5");
        expect_empty(1, "caps_five_events");

        // Pause sequence is swallowed
        do_reset();
        send_byte(8'hE1);
        send_byte(8'h14);
        @(negedge clk);
        check("pause_ctrl_mid", {31'd0, ctrl[0]}, 32'd0);
        send_byte(8'h77);
        send_byte(8'hE1);
        send_byte(8'hF0);
        send_byte(8'h14);
        send_byte(8'hF0);
        send_byte(8'h77);
        send_byte(8'h1C);
        pop_expect(0, 12'h81C, "after_pause");
        expect_empty(0, "pause_no_events");
        check("pause_ctrl_end", {31'd0, ctrl[0]}, 32'd0);

        // Overflow: nine make/break pairs into an 8-deep FIFO
        do_reset();
        for (int i = 0; i < 9; i++) begin
            send_byte(8'h20 + 8'(i));
            send_byte(8'hF0);
            send_byte(8'h20 + 8'(i));
        end
        @(negedge clk);
        check("overflow_set", {31'd0, overflow[0]}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            pop_expect(0, 12'h820 + 12'(i), "ovf_make");
            pop_expect(0, 12'h020 + 12'(i), "ovf_break");
        end
        expect_empty(0, "ovf_drained");
        check("overflow_sticky", {31'd0, overflow[0]}, 32'd1);

        // clr after E0 with an event queued
        send_byte(8'h2A);
        send_byte(8'hE0);
        @(negedge clk);
        check("pre_clr_valid", {31'd0, evt_valid[0]}, 32'd1);
        clr = 1'b1;
        #1;
        check("clr_async_valid", {31'd0, evt_valid[0]}, 32'd0);
        check("clr_async_ovf",   {31'd0, overflow[0]},  32'd0);
        @(negedge clk);
        clr = 1'b0;
        send_byte(8'h1C);
        pop_expect(0, 12'h81C, "clr_back_to_idle");
        expect_empty(0, "clr_final_empty");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
